// File: rtl/sixteen_sign_div.sv
// Sequential sign-magnitude restoring divider: 2W-bit magnitude / W-bit magnitude,
// one quotient bit per clock, with divide-by-zero and quotient-overflow prechecks.
module sixteen_sign_div #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  input  logic           dsign,
  input  logic           vsign,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           sign,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  qreg_q, qreg_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quotient_q, quotient_d;
  logic [W-1:0]  remainder_q, remainder_d;
  logic          sign_q, sign_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  // Partial remainder is always below the divisor, so the shifted trial value fits in W+1
  // bits and the subtraction result fits in W bits (the carry-out bit is never needed).
  logic [W:0]    trial;
  logic          trialGe;
  logic [W-1:0]  remSub;
  logic [W-1:0]  remNext;
  logic [W-1:0]  qNext;

  assign trial   = {rem_q, qreg_q[W-1]};
  assign trialGe = trial >= {1'b0, div_q};
  assign remSub  = trial[W-1:0] - div_q;
  assign remNext = trialGe ? remSub : trial[W-1:0];
  assign qNext   = {qreg_q[W-2:0], trialGe};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      qreg_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      qreg_q      <= qreg_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    qreg_d      = qreg_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          div_d  = divisor;
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
          sign_d = dsign ^ vsign;
          if (divisor == '0) begin
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[W-1:0];
            state_d     = DONE;
          end else if (dividend[2*W-1:W] >= divisor) begin
            ovf_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
            state_d     = DONE;
          end else begin
            rem_d   = dividend[2*W-1:W];
            qreg_d  = dividend[W-1:0];
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d  = remNext;
        qreg_d = qNext;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          quotient_d  = qNext;
          remainder_d = remNext;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign sign      = sign_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_sixteen_sign_div.sv
// Self-checking bench for sixteen_sign_div: directed cases plus randomized operations
// compared every cycle against an arithmetic reference model.
module tb_sixteen_sign_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        dsign;
  logic        vsign;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        sign;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        s;
    logic        ovf;
    logic        dbz;
    int          lat;
  } res_t;

  sixteen_sign_div #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .dsign(dsign), .vsign(vsign), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .sign(sign), .ovf(ovf), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer division; lat counts edges from the accept edge
  // (inclusive) to the edge after which done is visible.
  function automatic res_t model(logic [31:0] dvd, logic [15:0] dvs, logic ds, logic vs);
    res_t m;
    m.s   = ds ^ vs;
    m.ovf = 1'b0;
    m.dbz = 1'b0;
    if (dvs == 16'd0) begin
      m.dbz = 1'b1;
      m.q   = 16'hFFFF;
      m.r   = dvd[15:0];
      m.lat = 1;
    end else if (dvd[31:16] >= dvs) begin
      m.ovf = 1'b1;
      m.q   = 16'hFFFF;
      m.r   = 16'h0000;
      m.lat = 1;
    end else begin
      m.q   = 16'(dvd / {16'd0, dvs});
      m.r   = 16'(dvd % {16'd0, dvs});
      m.lat = 17;
    end
    return m;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT against the model n edges after the accept edge (n=1 is the accept).
  task automatic checkOutput(res_t e, int n);
    if (n <= e.lat) begin
      checkVal("busy", 32'(busy), 32'd1);
      checkVal("done", 32'(done), 32'(n == e.lat));
      checkVal("sign", 32'(sign), 32'(e.s));
      if (n == e.lat) begin
        checkVal("quotient", 32'(quotient), 32'(e.q));
        checkVal("remainder", 32'(remainder), 32'(e.r));
        checkVal("ovf", 32'(ovf), 32'(e.ovf));
        checkVal("dbz", 32'(dbz), 32'(e.dbz));
      end else begin
        checkVal("ovf_inflight", 32'(ovf), 32'd0);
        checkVal("dbz_inflight", 32'(dbz), 32'd0);
      end
    end else begin
      checkVal("busy_idle", 32'(busy), 32'd0);
      checkVal("done_idle", 32'(done), 32'd0);
      checkVal("quotient_hold", 32'(quotient), 32'(e.q));
      checkVal("remainder_hold", 32'(remainder), 32'(e.r));
    end
  endtask

  task automatic checkAllZero(string tag);
    checkVal({tag, "_busy"}, 32'(busy), 32'd0);
    checkVal({tag, "_done"}, 32'(done), 32'd0);
    checkVal({tag, "_quotient"}, 32'(quotient), 32'd0);
    checkVal({tag, "_remainder"}, 32'(remainder), 32'd0);
    checkVal({tag, "_flags"}, {29'd0, sign, ovf, dbz}, 32'd0);
  endtask

  // hold keeps start asserted (and inputs stable) through the whole operation;
  // abortAt > 0 pulses reset asynchronously that many edges after accept.
  task automatic applyStimulus(logic [31:0] dvd, logic [15:0] dvs, logic ds, logic vs,
                               bit hold, int abortAt);
    res_t e;
    e = model(dvd, dvs, ds, vs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    dsign    = ds;
    vsign    = vs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start    = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      dsign    = 1'($urandom);
      vsign    = 1'($urandom);
    end
    for (int n = 1; n <= e.lat + 1; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (n == abortAt) begin
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        repeat (2) begin
          @(posedge clk);
          #1;
          checkAllZero("abort_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      checkOutput(e, n);
    end
    if (hold) begin
      @(posedge clk);
      #1;
      checkOutput(e, 1);
      start = 1'b0;
      for (int n = 2; n <= e.lat + 1; n++) begin
        @(posedge clk);
        #1;
        checkOutput(e, n);
      end
    end
  endtask

  task automatic pinModel();
    res_t m;
    m = model(32'h0000EA60, 16'd200, 1'b1, 1'b0);
    checkVal("pin1_q", 32'(m.q), 32'd300);
    checkVal("pin1_r", 32'(m.r), 32'd0);
    checkVal("pin1_s", 32'(m.s), 32'd1);
    checkVal("pin1_lat", 32'(m.lat), 32'd17);
    m = model(32'h0000EA6F, 16'd200, 1'b1, 1'b1);
    checkVal("pin2_qr", {m.q, m.r}, {16'd300, 16'd15});
    checkVal("pin2_s", 32'(m.s), 32'd0);
    m = model(32'h12345678, 16'd0, 1'b0, 1'b0);
    checkVal("pin3", {m.q, m.r}, 32'hFFFF5678);
    checkVal("pin3_dbz", {m.dbz, m.ovf, 30'(m.lat)}, {2'b10, 30'd1});
    m = model(32'h00C80000, 16'd200, 1'b0, 1'b0);
    checkVal("pin4", {m.q, m.r}, 32'hFFFF0000);
    checkVal("pin4_ovf", {m.dbz, m.ovf, 30'(m.lat)}, {2'b01, 30'd1});
    m = model(32'hFFFE0001, 16'hFFFF, 1'b0, 1'b0);
    checkVal("pin5", {m.q, m.r}, 32'hFFFF0000);
    checkVal("pin5_ovf", 32'(m.ovf), 32'd0);
  endtask

  initial begin
    int sel;
    int dvsInt;
    int hiInt;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    dsign    = 1'b0;
    vsign    = 1'b0;
    #3;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    pinModel();

    applyStimulus(32'h0000EA60, 16'd200, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(32'h0000EA6F, 16'd200, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(32'h12345678, 16'd0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(32'h00C80000, 16'd200, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(32'hFFFE0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(32'h0000EA60, 16'd200, 1'b1, 1'b0, 1'b0, 8);
    applyStimulus(32'h0000EA60, 16'd200, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(32'h00000000, 16'd1, 1'b1, 1'b1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      sel    = int'($urandom_range(7, 0));
      dvsInt = (sel == 0) ? 0 : int'($urandom_range(65535, 1));
      if (sel == 1 || dvsInt == 0) hiInt = int'($urandom_range(65535, dvsInt));
      else                         hiInt = int'($urandom_range(dvsInt - 1, 0));
      applyStimulus({16'(hiInt), 16'($urandom)}, 16'(dvsInt), 1'($urandom), 1'($urandom),
                    1'($urandom_range(3, 0) == 0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
